shift_ser_ctrl: RTL and testbench

Sequencing controller for the N-bit universal shift register (ctrl encoding 00 hold, 01 shift left, 10 shift right, 11 parallel load). It accepts a parallel word over a valid/ready handshake and drives the register's ctrl/d inputs to load the word. It then shifts the word out one bit per accepted cycle in the requested direction, with consumer backpressure. It sits between a word-producing client and one univ_shift_reg instance, making that register a P2S serializer.

---
 rtl/shift_ser_ctrl.sv | 120 ++++++++++++
 tb/tb_shift_ser_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ser_ctrl.sv
// Sequencing controller that turns a universal shift register into a P2S serializer.
// Accepts a word over valid/ready, loads it, then shifts it out one bit per consumer handshake.
module shift_ser_ctrl #(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [N-1:0] din,
   input  logic         dir,
   input  logic         fill,
   output logic [1:0]   sr_ctrl,
   output logic [N-1:0] sr_d,
   input  logic [N-1:0] sr_q,
   output logic         ser_out,
   output logic         ser_valid,
   input  logic         ser_ready,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CTRL_HOLD  = 2'b00;
   localparam logic [1:0] CTRL_LEFT  = 2'b01;
   localparam logic [1:0] CTRL_RIGHT = 2'b10;
   localparam logic [1:0] CTRL_LOAD  = 2'b11;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [N-1:0]       din_q;
   logic               dir_q;
   logic               fill_q;
   logic               accept;

   // State, bit counter and word captures
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         din_q   <= '0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (accept) begin
            din_q  <= din;
            dir_q  <= dir;
            fill_q <= fill;
         end
      end
   end

   // Next state and output decode; outputs follow state so a reset forces hold at once
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      accept      = 1'b0;
      start_ready = 1'b0;
      sr_ctrl     = CTRL_HOLD;
      sr_d        = '0;
      ser_out     = 1'b0;
      ser_valid   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               accept  = 1'b1;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            sr_ctrl = CTRL_LOAD;
            sr_d    = din_q;
            count_d = '0;
            state_d = S_SHIFT;
         end

         S_SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = dir_q ? sr_q[0] : sr_q[N-1];
            sr_d      = {N{fill_q}};
            if (ser_ready) begin
               sr_ctrl = dir_q ? CTRL_RIGHT : CTRL_LEFT;
               // Counter saturates at the last bit rather than stepping past it
               if (count_q == LAST_BIT) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Bench for shift_ser_ctrl: a behavioural universal shift register closes the loop, and a
// transaction-level model predicts every output on every cycle alongside directed literal checks.
module tb_shift_ser_ctrl;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [N-1:0] din = '0;
   logic         dir = 1'b0;
   logic         fill = 1'b0;
   logic [1:0]   sr_ctrl;
   logic [N-1:0] sr_d;
   logic [N-1:0] sr_q;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_ready = 1'b1;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   shift_ser_ctrl #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .din         (din),
      .dir         (dir),
      .fill        (fill),
      .sr_ctrl     (sr_ctrl),
      .sr_d        (sr_d),
      .sr_q        (sr_q),
      .ser_out     (ser_out),
      .ser_valid   (ser_valid),
      .ser_ready   (ser_ready),
      .busy        (busy),
      .done        (done)
   );

   // Universal shift register the controller drives; shifted-in bit comes from d
   logic [N-1:0] q_reg = '0;
   assign sr_q = q_reg;
   always @(posedge clk) begin
      case (sr_ctrl)
         2'b01:   q_reg <= {q_reg[N-2:0], sr_d[0]};
         2'b10:   q_reg <= {sr_d[N-1], q_reg[N-1:1]};
         2'b11:   q_reg <= sr_d;
         default: q_reg <= q_reg;
      endcase
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   int edges = 0;
   always @(posedge clk) edges++;

   // Transaction model: idle, or a word that is loading, streaming bits, or finishing
   bit           m_active = 1'b0;
   bit           m_loading = 1'b0;
   int           m_bits = 0;
   logic [N-1:0] m_din = '0;
   logic         m_dir = 1'b0;
   logic         m_fill = 1'b0;

   int   acc_edge = 0;
   bit   done_seen = 1'b0;
   int   done_rel = 0;
   logic obs[$];

   always @(negedge clk) begin
      logic         e_rdy, e_valid, e_out, e_busy, e_done;
      logic [1:0]   e_ctrl;
      logic [N-1:0] e_d;
      e_rdy = 1'b1; e_valid = 1'b0; e_out = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_ctrl = 2'b00; e_d = '0;
      if (reset && m_active) begin
         e_rdy = 1'b0;
         e_busy = 1'b1;
         if (m_loading) begin
            e_ctrl = 2'b11;
            e_d = m_din;
         end else if (m_bits < N) begin
            e_valid = 1'b1;
            e_out = m_dir ? m_din[m_bits] : m_din[N-1-m_bits];
            e_d = {N{m_fill}};
            e_ctrl = ser_ready ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
         end else begin
            e_done = 1'b1;
         end
      end
      check("start_ready", start_ready, e_rdy);
      check("sr_ctrl", sr_ctrl, e_ctrl);
      check("sr_d", sr_d, e_d);
      check("ser_valid", ser_valid, e_valid);
      check("ser_out", ser_out, e_out);
      check("busy", busy, e_busy);
      check("done", done, e_done);

      if (!reset) begin
         m_active = 1'b0;
      end else begin
         if (start_valid && start_ready) acc_edge = edges;
         if (done) begin
            done_seen = 1'b1;
            done_rel = edges - acc_edge;
         end
         if (ser_valid && ser_ready) obs.push_back(ser_out);
         if (!m_active) begin
            if (start_valid) begin
               m_active = 1'b1;
               m_loading = 1'b1;
               m_bits = 0;
               m_din = din;
               m_dir = dir;
               m_fill = fill;
            end
         end else if (m_loading) begin
            m_loading = 1'b0;
         end else if (m_bits < N) begin
            if (ser_ready) m_bits++;
         end else begin
            m_active = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input logic [7:0] w, input logic d, input logic f,
                           input int stall_at, input int stall_len, input bit hold_ff,
                           input logic [7:0] exp_bits, input int exp_done,
                           input logic [7:0] exp_q, input string tag);
      logic [7:0] got;
      int r;
      obs.delete();
      done_seen = 1'b0;
      start_valid = 1'b1; din = w; dir = d; fill = f; ser_ready = 1'b1;
      tick();
      if (hold_ff) begin
         din = 8'hFF; dir = 1'b0; fill = 1'b0;
      end else begin
         start_valid = 1'b0; din = ~w; dir = ~d; fill = ~f;
      end
      r = 1;
      while (!done_seen && r < 60) begin
         ser_ready = (r >= stall_at && r < stall_at + stall_len) ? 1'b0 : 1'b1;
         if (!ser_ready) check({tag, "_stall_out"}, ser_out, 1'b1);
         tick();
         r++;
      end
      ser_ready = 1'b1;
      check({tag, "_done_seen"}, done_seen, 1'b1);
      check({tag, "_done_cycle"}, done_rel, exp_done);
      check({tag, "_bit_count"}, obs.size(), N);
      got = '0;
      for (int i = 0; i < obs.size() && i < 8; i++) got[7-i] = obs[i];
      check({tag, "_bits"}, got, exp_bits);
      check({tag, "_final_q"}, sr_q, exp_q);
   endtask

   initial begin
      int a1;
      tick();
      check("rst_start_ready", start_ready, 1'b1);
      check("rst_sr_ctrl", sr_ctrl, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ser_valid", ser_valid, 1'b0);
      tick();
      reset = 1'b1;
      repeat (10) tick();
      check("idle_q", sr_q, 8'h00);

      run_word(8'h1E, 1'b0, 1'b0, 0, 0, 1'b0, 8'h1E, 10, 8'h00, "msb");
      run_word(8'h1E, 1'b1, 1'b1, 0, 0, 1'b0, 8'h78, 10, 8'hFF, "lsb_fill");
      run_word(8'hA5, 1'b0, 1'b0, 4, 3, 1'b0, 8'hA5, 13, 8'h00, "backpressure");

      run_word(8'h1E, 1'b0, 1'b0, 0, 0, 1'b1, 8'h1E, 10, 8'h00, "busy_first");
      a1 = acc_edge;
      run_word(8'hFF, 1'b0, 1'b0, 0, 0, 1'b0, 8'hFF, 10, 8'h00, "busy_second");
      check("busy_spacing", acc_edge - a1, N + 3);

      // Abandon a word while its 4th bit is on the wire
      obs.delete();
      done_seen = 1'b0;
      start_valid = 1'b1; din = 8'h1E; dir = 1'b0; fill = 1'b0;
      tick();
      start_valid = 1'b0;
      repeat (4) tick();
      #2 reset = 1'b0;
      #1;
      check("arst_sr_ctrl", sr_ctrl, 2'b00);
      check("arst_ser_valid", ser_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_start_ready", start_ready, 1'b1);
      tick();
      repeat (3) tick();
      reset = 1'b1;
      repeat (2) tick();
      check("arst_no_done", done_seen, 1'b0);
      check("arst_bits_before", obs.size(), 3);
      run_word(8'h3C, 1'b1, 1'b0, 0, 0, 1'b0, 8'h3C, 10, 8'h00, "after_rst");

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
